pc_sequencer: RTL
=================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have port: clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_i  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: stall_i  input  1  hazard-unit hold request (load-use).
REQ-005 SHALL have port: branch_i  input  1  EX-stage instruction is a conditional branch.
REQ-006 SHALL have port: bne_i  input  1  EX branch type; 0 = BEQ, 1 = BNE.
REQ-007 SHALL have port: zero_i  input  1  ALU zero flag of the EX-stage compare.
REQ-008 SHALL have port: br_pc4_i  input  32  PC+4 of the EX-stage branch.
REQ-009 SHALL have port: br_imm_i  input  32  sign-extended branch immediate, in words.
REQ-010 SHALL have port: jump_i  input  1  ID-stage instruction is J.
REQ-011 SHALL have port: jump_pc4_i  input  32  PC+4 of the ID-stage jump.
REQ-012 SHALL have port: jump_addr_i  input  26  J-format target field.
REQ-013 SHALL have port: pc_o  output  32  current fetch PC (registered).
REQ-014 SHALL have port: pc_plus4_o  output  32  pc_o + 4.
REQ-015 SHALL have port: flush_if_id_o  output  1  squash IF/ID register this cycle.
REQ-016 SHALL have port: flush_id_ex_o  output  1  squash ID/EX register this cycle.
REQ-017 SHALL have port: pc_write_o  output  1  IF/ID write enable (0 while holding).
REQ-018 SHALL have port: redirect_cnt_o  output  16  count of taken redirects, saturating.

Function
REQ-019 Branch taken SHALL be branch_i & (zero_i ^ bne_i), evaluated combinationally.
REQ-020 Branch target SHALL be br_pc4_i + (br_imm_i << 2), truncated to 32 bits (wraps modulo 2^32).
REQ-021 Jump target SHALL be {jump_pc4_i[31:28], jump_addr_i, 2'b00}.
REQ-022 Next-PC priority SHALL be: taken branch > stall_i > valid jump > pc_o + 4.
REQ-023 FSM states SHALL be RUN, HOLD, REDIRECT; reset state RUN.
REQ-024 RUN: taken branch -> REDIRECT; else stall_i -> HOLD; else remain RUN.
REQ-025 HOLD: pc_o and IF/ID held (pc_write_o=0, flush_id_ex_o=1 bubble); taken branch -> REDIRECT; stall_i low -> RUN.
REQ-026 REDIRECT lasts exactly one cycle; jump_i SHALL be ignored (wrong-path slot); taken branch -> REDIRECT again; else stall_i -> HOLD; else RUN.
REQ-027 On taken branch: flush_if_id_o=1 and flush_id_ex_o=1 in the same cycle, PC loads target next edge, stall_i ignored.
REQ-028 On valid jump (not masked, no stall, no taken branch): flush_if_id_o=1 only, PC loads jump target next edge.
REQ-029 pc_write_o SHALL be 0 only when stall_i is honoured; 1 otherwise.
REQ-030 redirect_cnt_o SHALL increment once per cycle a taken branch or valid jump loads PC, holding at 16'hFFFF.
REQ-031 Flush outputs SHALL be combinational from current inputs and state; pc_o SHALL be registered.

Reset
REQ-032 While rst_i=0: pc_o=RESET_PC, state=RUN, redirect_cnt_o=0, flushes=0, pc_write_o=1, asynchronously.
REQ-033 Reset asserted mid-HOLD or mid-REDIRECT SHALL abandon the operation; first post-reset fetch is RESET_PC.

Structure
REQ-034 State encoding, BEQ/BNE codes and default RESET_PC SHALL live in a shared package (pc_seq_pkg).
REQ-035 Target arithmetic (REQ-020, REQ-021) SHALL be one combinational sub-module, pc_target_calc.

Verification
REQ-036 Reset release, no events, 3 cycles -> pc_o 0,4,8,C; no flushes.
REQ-037 pc_o=0x40, BEQ, zero_i=1, br_pc4_i=0x40, br_imm_i=0xFFFF_FFFE -> both flushes 1 that cycle, pc_o=0x38 next, counter=1.
REQ-038 stall_i=1 for 2 cycles at pc_o=0x10 -> pc_o stays 0x10, pc_write_o=0, flush_id_ex_o=1; then pc_o=0x14.
REQ-039 Taken branch with stall_i=1 and jump_i=1 same cycle -> branch target loaded, stall ignored, jump dropped.
REQ-040 Jump_i=1 in the REDIRECT cycle -> ignored, pc_o = target+4; jump_pc4_i=0xA000_0000, jump_addr_i=0x10 in RUN -> pc_o=0xA000_0040.
REQ-041 br_pc4_i=0xFFFF_FFFC, br_imm_i=2 -> pc_o=0x0000_0004 (wrap); rst_i pulse mid-HOLD -> pc_o=RESET_PC immediately.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared constants, state encoding and branch decode for the PC sequencer.
package pc_seq_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned JADDR_W = 26;
  localparam int unsigned CNT_W   = 16;

  localparam logic [XLEN-1:0]  DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0]  JUMP_REGION_MASK = 32'hF000_0000;
  localparam logic [CNT_W-1:0] CNT_MAX          = '1;

  // Branch type codes carried on bne_i
  localparam logic BR_BEQ = 1'b0;
  localparam logic BR_BNE = 1'b1;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_HOLD     = 2'd1,
    ST_REDIRECT = 2'd2
  } seq_state_e;

  // Resolve a conditional branch from its type and the ALU zero flag
  function automatic logic branch_taken(input logic branch, input logic bne, input logic zero);
    return branch & (((bne == BR_BEQ) & zero) | ((bne == BR_BNE) & ~zero));
  endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Combinational branch and jump target arithmetic.
module pc_target_calc
  import pc_seq_pkg::*;
(
  input  logic [XLEN-1:0]    br_pc4,
  input  logic [XLEN-1:0]    br_imm,
  input  logic [XLEN-1:0]    jump_pc4,
  input  logic [JADDR_W-1:0] jump_addr,
  output logic [XLEN-1:0]    br_target_c,
  output logic [XLEN-1:0]    jump_target_c
);

  // Word-scaled branch offset; the sum wraps modulo 2^32
  assign br_target_c = br_pc4 + (br_imm << 2);

  // Jump stays inside the 256 MB region of the jump's PC+4
  assign jump_target_c = (jump_pc4 & JUMP_REGION_MASK) | XLEN'({jump_addr, 2'b00});

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: branch/jump redirects, load-use hold and pipeline flush control.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               stall_i,
  input  logic               branch_i,
  input  logic               bne_i,
  input  logic               zero_i,
  input  logic [XLEN-1:0]    br_pc4_i,
  input  logic [XLEN-1:0]    br_imm_i,
  input  logic               jump_i,
  input  logic [XLEN-1:0]    jump_pc4_i,
  input  logic [JADDR_W-1:0] jump_addr_i,
  output logic [XLEN-1:0]    pc_o,
  output logic [XLEN-1:0]    pc_plus4_o,
  output logic               flush_if_id_o,
  output logic               flush_id_ex_o,
  output logic               pc_write_o,
  output logic [CNT_W-1:0]   redirect_cnt_o
);

  seq_state_e       state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  br_target_c, jump_target_c;
  logic             taken_c, stall_hon_c, jump_ok_c, load_c;

  pc_target_calc u_target (
    .br_pc4        (br_pc4_i),
    .br_imm        (br_imm_i),
    .jump_pc4      (jump_pc4_i),
    .jump_addr     (jump_addr_i),
    .br_target_c   (br_target_c),
    .jump_target_c (jump_target_c)
  );

  assign pc_o           = pc_q;
  assign pc_plus4_o     = pc_q + XLEN'(4);
  assign redirect_cnt_o = cnt_q;

  // Event decode, next-state, next-PC and flush/write-enable generation
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q + XLEN'(4);
    flush_if_id_o = 1'b0;
    flush_id_ex_o = 1'b0;
    pc_write_o    = 1'b1;
    load_c        = 1'b0;

    // Reset forces all events inactive so the flush/write outputs sit at idle values
    taken_c     = rst_i & branch_taken(branch_i, bne_i, zero_i);
    stall_hon_c = rst_i & ~taken_c & stall_i;
    // The slot right after a taken branch holds a wrong-path instruction: its jump is dropped
    jump_ok_c   = rst_i & jump_i & ~stall_i & ~taken_c & (state_q != ST_REDIRECT);

    if (taken_c) begin
      state_d       = ST_REDIRECT;
      pc_d          = br_target_c;
      flush_if_id_o = 1'b1;
      flush_id_ex_o = 1'b1;
      load_c        = 1'b1;
    end else if (stall_hon_c) begin
      state_d       = ST_HOLD;
      pc_d          = pc_q;
      pc_write_o    = 1'b0;
      flush_id_ex_o = 1'b1;
    end else begin
      state_d = ST_RUN;
      if (jump_ok_c) begin
        pc_d          = jump_target_c;
        flush_if_id_o = 1'b1;
        load_c        = 1'b1;
      end
    end
  end

  // State, PC and saturating redirect counter registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (load_c && (cnt_q != CNT_MAX)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule
